// File: rtl/multi_cycle_cpu_if.sv
// Memory bus between the multi-cycle CPU (master) and its memory (slave).
// A transfer completes on any rising edge where mem_req and mem_ready are both high.
interface multi_cycle_cpu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-I subset CPU: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Optional macro MULTI_CYCLE_CPU_TRAP_EN: undefined encodings set a sticky trap
// and halt; without it they execute as a NOP.
module multi_cycle_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    multi_cycle_cpu_if.master mem,
    output logic [31:0]       pc_out,
    output logic              retire,
    output logic              trap
);

    localparam int RW = $clog2(NUM_REGS);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [2:0]    state;
    logic [31:0]   pc;
    logic [31:0]   ir;
    logic [31:0]   op_a;
    logic [31:0]   op_b;
    logic [31:0]   target;
    logic [31:0]   res;
    logic [31:0]   regs [NUM_REGS];

    // Instruction fields
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [4:0]    shamt;
    logic [RW-1:0] rs_idx;
    logic [RW-1:0] rt_idx;
    logic [RW-1:0] rd_idx;
    logic [RW-1:0] wb_idx;
    logic [31:0]   sext;
    logic          funct_ok;
    logic          is_alu_op;
    logic          is_mem_op;
    logic [31:0]   alu;
    logic [31:0]   ea;
    logic [31:0]   next_pc;

    assign opcode = ir[31:26];
    assign funct  = ir[5:0];
    assign shamt  = ir[10:6];
    assign rs_idx = ir[21 +: RW];
    assign rt_idx = ir[16 +: RW];
    assign rd_idx = ir[11 +: RW];
    assign sext   = {{16{ir[15]}}, ir[15:0]};
    assign ea     = op_a + sext;
    assign pc_out = pc;

    // Decode instruction class; an unknown R-type funct is not an ALU op
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        funct_ok = 1'b0;
        case (funct)
            FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
            default: funct_ok = 1'b0;
        endcase
        is_alu_op = (opcode == OP_ADDI) || (opcode == OP_RTYPE && funct_ok);
        is_mem_op = (opcode == OP_LW) || (opcode == OP_SW);
        wb_idx    = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
    end

    // ALU: 32-bit wrap-around arithmetic, signed slt, zero-fill shifts of rt
    always_comb begin
        alu = '0;
        if (opcode == OP_ADDI) begin
            alu = op_a + sext;
        end else begin
            case (funct)
                FN_ADD:  alu = op_a + op_b;
                FN_SUB:  alu = op_a - op_b;
                FN_AND:  alu = op_a & op_b;
                FN_OR:   alu = op_a | op_b;
                FN_SLT:  alu = {31'b0, $signed(op_a) < $signed(op_b)};
                FN_SLL:  alu = op_b << shamt;
                FN_SRL:  alu = op_b >> shamt;
                default: alu = '0;
            endcase
        end
    end

    // PC after a control-flow instruction in EXEC (pc already holds PC+4)
    always_comb begin
        next_pc = pc;
        if (opcode == OP_BEQ && op_a == op_b)
            next_pc = target;
        else if (opcode == OP_J)
            next_pc = {pc[31:28], ir[25:0], 2'b00};
    end

    // Retire in WB, in EXEC for beq/j/NOP, and on the store handshake in MEM
    always_comb begin
        retire = (state == S_WB) ||
                 (state == S_EXEC && !is_alu_op && !is_mem_op) ||
                 (state == S_MEM && mem.mem_we && mem.mem_req && mem.mem_ready);
    end

    // Main FSM, registered memory bus outputs and datapath latches
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state         <= S_FETCH;
            pc            <= RESET_PC;
            ir            <= '0;
            op_a          <= '0;
            op_b          <= '0;
            target        <= '0;
            res           <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (!mem.mem_req) begin
                        // Only reached straight after reset: raise the first fetch
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= pc;
                    end else if (mem.mem_ready) begin
                        ir          <= mem.mem_rdata;
                        pc          <= pc + 32'd4;
                        mem.mem_req <= 1'b0;
                        state       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    op_a   <= regs[rs_idx];
                    op_b   <= regs[rt_idx];
                    target <= pc + (sext << 2);
`ifdef MULTI_CYCLE_CPU_TRAP_EN
                    if (!(is_alu_op || is_mem_op || opcode == OP_BEQ || opcode == OP_J))
                        state <= S_HALT;
                    else
                        state <= S_EXEC;
`else
                    state <= S_EXEC;
`endif
                end
                S_EXEC: begin
                    if (is_alu_op) begin
                        res   <= alu;
                        state <= S_WB;
                    end else if (is_mem_op) begin
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= (opcode == OP_SW);
                        mem.mem_addr  <= ea & ~32'h3;
                        mem.mem_wdata <= op_b;
                        state         <= S_MEM;
                    end else begin
                        // beq, j and undefined encodings complete here
                        pc           <= next_pc;
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= next_pc;
                        state        <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem.mem_ready) begin
                        if (mem.mem_we) begin
                            mem.mem_req  <= 1'b1;
                            mem.mem_we   <= 1'b0;
                            mem.mem_addr <= pc;
                            state        <= S_FETCH;
                        end else begin
                            res         <= mem.mem_rdata;
                            mem.mem_req <= 1'b0;
                            state       <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    mem.mem_req  <= 1'b1;
                    mem.mem_we   <= 1'b0;
                    mem.mem_addr <= pc;
                    state        <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // Register file write port; register 0 is never written so it reads as zero
    always_ff @(posedge clk) begin
        // NOTE: the register file must clear on reset, so it is built from flops rather than a RAM macro.
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (state == S_WB && wb_idx != '0) begin
            regs[wb_idx] <= res;
        end
    end

`ifdef MULTI_CYCLE_CPU_TRAP_EN
    // Sticky illegal-instruction flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst)
            trap <= 1'b0;
        else if (state == S_DECODE &&
                 !(is_alu_op || is_mem_op || opcode == OP_BEQ || opcode == OP_J))
            trap <= 1'b1;
    end
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Self-checking bench for multi_cycle_cpu: table-driven program with per-instruction
// latency/PC expectations, store scoreboard, plus reset, branch-loop and jump sequences.
module tb_multi_cycle_cpu;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        int          lat;
        logic [31:0] next_pc;
        logic        st;
        logic [31:0] st_addr;
        logic [31:0] st_data;
        logic        illegal;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } store_t;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    logic [31:0] pc_out, pc_out2;
    logic retire, retire2, trap, trap2;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [31:0] prog  [0:255];
    logic [31:0] dmem  [0:255];
    bit          dvalid [0:255];
    logic [31:0] stall_addr;
    int          stall_cycles;
    int          wcnt = 0;

    vec_t   vecs [$];
    store_t exp_q [$];

    multi_cycle_cpu_if bus ();
    multi_cycle_cpu_if bus2 ();

    multi_cycle_cpu dut (
        .clk    (clk),
        .rst    (rst),
        .mem    (bus.master),
        .pc_out (pc_out),
        .retire (retire),
        .trap   (trap)
    );

    multi_cycle_cpu #(.RESET_PC(32'h1000_0000)) dut_j (
        .clk    (clk),
        .rst    (rst2),
        .mem    (bus2.master),
        .pc_out (pc_out2),
        .retire (retire2),
        .trap   (trap2)
    );

    always #5 clk = ~clk;

    // Memory model: stores overlay the program image; one address can be stalled
    assign bus.mem_ready = bus.mem_req && (bus.mem_addr != stall_addr || wcnt >= stall_cycles);
    assign bus.mem_rdata = dvalid[bus.mem_addr[9:2]] ? dmem[bus.mem_addr[9:2]] : prog[bus.mem_addr[9:2]];
    assign bus2.mem_ready = bus2.mem_req;
    assign bus2.mem_rdata = 32'h0800_0040;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
        if (bus.mem_req && bus.mem_ready) begin
            if (bus.mem_we) begin
                dmem[bus.mem_addr[9:2]]   <= bus.mem_wdata;
                dvalid[bus.mem_addr[9:2]] <= 1'b1;
            end
            wcnt <= 0;
        end else if (bus.mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Store scoreboard: every store handshake must match the oldest expected store
    always @(negedge clk) begin
        if (!rst && bus.mem_req && bus.mem_we && bus.mem_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected store addr", bus.mem_addr, 32'hxxxx_xxxx);
            end else begin
                store_t e;
                e = exp_q.pop_front();
                check("store addr", bus.mem_addr, e.addr);
                check("store data", bus.mem_wdata, e.data);
            end
        end
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] instr, input int lat,
                                input logic [31:0] next_pc, input logic st,
                                input logic [31:0] st_addr, input logic [31:0] st_data,
                                input logic illegal);
        vec_t v;
        v.addr = addr; v.instr = instr; v.lat = lat; v.next_pc = next_pc;
        v.st = st; v.st_addr = st_addr; v.st_data = st_data; v.illegal = illegal;
        return v;
    endfunction

    task automatic wait_retire(output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (retire) begin
                ok = 1'b1;
                at = cyc;
            end
        end
    endtask

    initial begin
        int  at;
        int  last;
        bit  ok;

        // addr, instr, latency, next pc, store?, store addr, store data, illegal
        vecs.push_back(mk(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd5),            4, 32'h04, 0, 0, 0, 0));
        vecs.push_back(mk(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'd7),            4, 32'h08, 0, 0, 0, 0));
        vecs.push_back(mk(32'h08, enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20),       4, 32'h0C, 0, 0, 0, 0));
        vecs.push_back(mk(32'h0C, {6'h02, 26'h10},                            3, 32'h40, 0, 0, 0, 0));
        vecs.push_back(mk(32'h40, enc_i(6'h2B, 5'd0, 5'd3, 16'h0010),         6, 32'h44, 1, 32'h10, 32'd12, 0));
        vecs.push_back(mk(32'h44, enc_i(6'h23, 5'd0, 5'd4, 16'h0010),         7, 32'h48, 0, 0, 0, 0));
        vecs.push_back(mk(32'h48, enc_i(6'h2B, 5'd0, 5'd4, 16'h0100),         4, 32'h4C, 1, 32'h100, 32'd12, 0));
        vecs.push_back(mk(32'h4C, enc_r(5'd1, 5'd2, 5'd5, 5'd0, 6'h22),       4, 32'h50, 0, 0, 0, 0));
        vecs.push_back(mk(32'h50, enc_r(5'd1, 5'd2, 5'd6, 5'd0, 6'h24),       4, 32'h54, 0, 0, 0, 0));
        vecs.push_back(mk(32'h54, enc_r(5'd1, 5'd2, 5'd7, 5'd0, 6'h25),       4, 32'h58, 0, 0, 0, 0));
        vecs.push_back(mk(32'h58, enc_r(5'd5, 5'd1, 5'd8, 5'd0, 6'h2A),       4, 32'h5C, 0, 0, 0, 0));
        vecs.push_back(mk(32'h5C, enc_r(5'd1, 5'd5, 5'd9, 5'd0, 6'h2A),       4, 32'h60, 0, 0, 0, 0));
        vecs.push_back(mk(32'h60, enc_r(5'd0, 5'd2, 5'd10, 5'd4, 6'h00),      4, 32'h64, 0, 0, 0, 0));
        vecs.push_back(mk(32'h64, enc_r(5'd0, 5'd5, 5'd11, 5'd28, 6'h02),     4, 32'h68, 0, 0, 0, 0));
        vecs.push_back(mk(32'h68, enc_i(6'h08, 5'd0, 5'd0, 16'd9),            4, 32'h6C, 0, 0, 0, 0));
        vecs.push_back(mk(32'h6C, enc_i(6'h08, 5'd5, 5'd12, 16'hFFFF),        4, 32'h70, 0, 0, 0, 0));
        vecs.push_back(mk(32'h70, enc_i(6'h2B, 5'd0, 5'd5, 16'h0104),         4, 32'h74, 1, 32'h104, 32'hFFFF_FFFE, 0));
        vecs.push_back(mk(32'h74, enc_i(6'h2B, 5'd0, 5'd6, 16'h0108),         4, 32'h78, 1, 32'h108, 32'd5, 0));
        vecs.push_back(mk(32'h78, enc_i(6'h2B, 5'd0, 5'd7, 16'h010C),         4, 32'h7C, 1, 32'h10C, 32'd7, 0));
        vecs.push_back(mk(32'h7C, enc_i(6'h2B, 5'd0, 5'd8, 16'h0110),         4, 32'h80, 1, 32'h110, 32'd1, 0));
        vecs.push_back(mk(32'h80, enc_i(6'h2B, 5'd0, 5'd9, 16'h0114),         4, 32'h84, 1, 32'h114, 32'd0, 0));
        vecs.push_back(mk(32'h84, enc_i(6'h2B, 5'd0, 5'd10, 16'h0118),        4, 32'h88, 1, 32'h118, 32'h70, 0));
        vecs.push_back(mk(32'h88, enc_i(6'h2B, 5'd0, 5'd11, 16'h011C),        4, 32'h8C, 1, 32'h11C, 32'hF, 0));
        vecs.push_back(mk(32'h8C, enc_i(6'h2B, 5'd0, 5'd0, 16'h0120),         4, 32'h90, 1, 32'h120, 32'd0, 0));
        vecs.push_back(mk(32'h90, enc_i(6'h2B, 5'd0, 5'd12, 16'h0124),        4, 32'h94, 1, 32'h124, 32'hFFFF_FFFD, 0));
        vecs.push_back(mk(32'h94, enc_i(6'h04, 5'd1, 5'd2, 16'd4),            3, 32'h98, 0, 0, 0, 0));
        vecs.push_back(mk(32'h98, enc_i(6'h04, 5'd2, 5'd2, 16'd1),            3, 32'hA0, 0, 0, 0, 0));
        vecs.push_back(mk(32'hA0, 32'hFC00_0000,                              3, 32'hA4, 0, 0, 0, 1));
        vecs.push_back(mk(32'hA4, enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F),       3, 32'hA8, 0, 0, 0, 1));
        vecs.push_back(mk(32'hA8, {6'h02, 26'h8},                             3, 32'h20, 0, 0, 0, 0));

        for (int i = 0; i < 256; i++) prog[i] = 32'h0;
        foreach (vecs[i]) prog[vecs[i].addr[9:2]] = vecs[i].instr;
        prog[32'h20 >> 2] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);   // beq $1,$1,-1 loop
        prog[32'h9C >> 2] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0130);   // skipped by taken beq

        // Reset state, first fetch timing, reset while a fetch is stalled
        rst = 1'b1; rst2 = 1'b1;
        stall_addr = 32'h0; stall_cycles = 1000;
        repeat (3) @(negedge clk);
        check("reset mem_req", {31'b0, bus.mem_req}, 32'd0);
        check("reset pc", pc_out, 32'h0);
        check("reset retire", {31'b0, retire}, 32'd0);
        check("reset trap", {31'b0, trap}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("first fetch req", {31'b0, bus.mem_req}, 32'd1);
        check("first fetch addr", bus.mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        check("stalled fetch held", {31'b0, bus.mem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("reset drops mem_req", {31'b0, bus.mem_req}, 32'd0);
        check("reset pending pc", pc_out, 32'h0);

        // Main program: data accesses to 0x10 wait two cycles
        stall_addr = 32'h10; stall_cycles = 2;
        @(negedge clk);
        rst = 1'b0;
        last = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].st) exp_q.push_back('{addr: vecs[i].st_addr, data: vecs[i].st_data});
`ifdef MULTI_CYCLE_CPU_TRAP_EN
            if (vecs[i].illegal) begin
                int nret = 0;
                int nreq = 0;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    if (retire) nret++;
                    if (bus.mem_req) nreq++;
                end
                check("trap set", {31'b0, trap}, 32'd1);
                check("trap no retire", nret, 0);
                check("trap no request", nreq, 0);
                check("trap pc", pc_out, vecs[i].addr + 32'd4);
                break;
            end
`endif
            wait_retire(at, ok);
            check($sformatf("retire seen [%0h]", vecs[i].addr), {31'b0, ok}, 32'd1);
            if (!ok) break;
            check($sformatf("latency [%0h]", vecs[i].addr), at - last, vecs[i].lat);
            last = at;
            @(negedge clk);
            check($sformatf("next pc [%0h]", vecs[i].addr), pc_out, vecs[i].next_pc);
        end

`ifndef MULTI_CYCLE_CPU_TRAP_EN
        // beq $1,$1,-1 at 0x20 spins back to itself every three cycles
        for (int i = 0; i < 3; i++) begin
            wait_retire(at, ok);
            check("loop retire seen", {31'b0, ok}, 32'd1);
            check("loop latency", at - last, 3);
            last = at;
            @(negedge clk);
            check("loop pc", pc_out, 32'h20);
        end
`endif

        // Reset clears the register file: storing $1 after reset must write 0
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst2 pc", pc_out, 32'h0);
        check("rst2 mem_req", {31'b0, bus.mem_req}, 32'd0);
        check("rst2 trap", {31'b0, trap}, 32'd0);
        prog[0] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0200);
        exp_q.push_back('{addr: 32'h200, data: 32'h0});
        rst = 1'b0;
        wait_retire(at, ok);
        check("post-reset retire seen", {31'b0, ok}, 32'd1);
        check("post-reset sw latency", at, 4);
        @(negedge clk);
        check("all stores seen", exp_q.size(), 0);

        // j 0x0000040 from PC 0x1000_0000 lands at 0x1000_0100
        rst2 = 1'b0;
        ok = 1'b0;
        at = 0;
        for (int k = 1; k <= 20 && !ok; k++) begin
            @(negedge clk);
            if (k == 1) check("jump first fetch addr", bus2.mem_addr, 32'h1000_0000);
            if (retire2) begin
                ok = 1'b1;
                at = k;
            end
        end
        check("jump latency", at, 3);
        @(negedge clk);
        check("jump pc", pc_out2, 32'h1000_0100);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
